// File: rtl/save_data_streamer_pkg.sv
// Shared sizes and FSM encoding for the save-RAM byte streamer.
package save_stream_pkg;

    localparam int SS_ADDR_W = 18;
    localparam int SS_LEN_W  = 19;
    localparam int SS_LANES  = 4;
    localparam int SS_LANE_W = $clog2(SS_LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WORD,
        S_LD_STROBE,
        S_LD_GAP,
        S_UL_STROBE,
        S_UL_WAIT,
        S_UL_PUSH,
        S_FINISH
    } ss_state_e;

    function automatic logic is_busy(input ss_state_e s);
        return !(s == S_IDLE || s == S_FINISH);
    endfunction

endpackage

// File: rtl/save_data_streamer_if.sv
// 32-bit word streams between the bridge save FIFO and the save-RAM streamer.
interface save_data_streamer_if;

    logic [31:0] in_word;
    logic        in_word_valid;
    logic        in_word_ready;
    logic [31:0] out_word;
    logic        out_word_valid;
    logic        out_word_ready;

    modport master (
        output in_word, in_word_valid, out_word_ready,
        input  in_word_ready, out_word, out_word_valid
    );

    modport slave (
        input  in_word, in_word_valid, out_word_ready,
        output in_word_ready, out_word, out_word_valid
    );

endinterface

// File: rtl/save_data_streamer_word_lane.sv
// Word shadow register with a byte-lane pointer: byte select for load,
// byte insert for unload.
module save_word_lane
    import save_stream_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 word_ld_i,
    input  logic                 byte_wr_i,
    input  logic                 lane_inc_i,
    input  logic [31:0]          word_i,
    input  logic [7:0]           byte_i,
    output logic [31:0]          word_o,
    output logic [7:0]           byte_o,
    output logic [SS_LANE_W-1:0] lane_o
);

    logic [31:0]          word_q, word_d;
    logic [SS_LANE_W-1:0] lane_q, lane_d;

    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (clr_i) begin
            word_d = '0;
            lane_d = '0;
        end else if (word_ld_i) begin
            word_d = word_i;
            lane_d = '0;
        end else begin
            if (byte_wr_i) begin
                word_d[{lane_q, 3'b000} +: 8] = byte_i;
            end
            if (lane_inc_i) begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word_o = word_q;
    assign byte_o = word_q[{lane_q, 3'b000} +: 8];
    assign lane_o = lane_q;

endmodule

// File: rtl/save_data_streamer.sv
// Moves save data between 32-bit bridge words and the core's byte-wide sd_buff
// port, one strobed byte access every ACCESS_CYCLES clocks.
module save_data_streamer
    import save_stream_pkg::*;
#(
    parameter int ACCESS_CYCLES = 16,
    parameter int RD_SAMPLE     = 12
) (
    input  logic                 clk_ppu_21_47,
    input  logic                 reset_n,
    input  logic                 load_start,
    input  logic                 unload_start,
    input  logic [SS_LEN_W-1:0]  xfer_len,
    save_data_streamer_if.slave  word_if,
    output logic [SS_ADDR_W-1:0] sd_buff_addr,
    output logic [7:0]           sd_buff_dout,
    output logic                 sd_buff_wr,
    output logic                 sd_buff_rd,
    input  logic [7:0]           sd_buff_din,
    output logic                 busy,
    output logic                 done
);

    localparam int TMR_W = $clog2(ACCESS_CYCLES);
    localparam logic [TMR_W-1:0] T_END = TMR_W'(ACCESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_PRE = TMR_W'(ACCESS_CYCLES - 2);
    localparam logic [TMR_W-1:0] T_SMP = TMR_W'(RD_SAMPLE);

    ss_state_e            state_q, state_d;
    logic [SS_LEN_W-1:0]  count_q, count_d;
    logic [SS_LEN_W-1:0]  len_q, len_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [SS_LEN_W-1:0]  count_inc;
    logic                 last_byte;

    logic                 lane_clr, lane_word_ld, lane_byte_wr, lane_inc;
    logic [31:0]          shadow_word;
    logic [7:0]           lane_byte;
    logic [SS_LANE_W-1:0] lane;
    logic                 lane_full;

    assign count_inc = count_q + 1'b1;
    assign last_byte = (count_inc == len_q);
    assign lane_full = (lane == SS_LANE_W'(SS_LANES - 1));

    save_word_lane u_lane (
        .clk_i      (clk_ppu_21_47),
        .rst_ni     (reset_n),
        .clr_i      (lane_clr),
        .word_ld_i  (lane_word_ld),
        .byte_wr_i  (lane_byte_wr),
        .lane_inc_i (lane_inc),
        .word_i     (word_if.in_word),
        .byte_i     (sd_buff_din),
        .word_o     (shadow_word),
        .byte_o     (lane_byte),
        .lane_o     (lane)
    );

    always_comb begin
        state_d                = state_q;
        count_d                = count_q;
        len_d                  = len_q;
        timer_d                = timer_q;
        lane_clr               = 1'b0;
        lane_word_ld           = 1'b0;
        lane_byte_wr           = 1'b0;
        lane_inc               = 1'b0;
        word_if.in_word_ready  = 1'b0;
        word_if.out_word_valid = 1'b0;
        sd_buff_wr             = 1'b0;
        sd_buff_rd             = 1'b0;
        done                   = 1'b0;
        busy                   = is_busy(state_q);

        case (state_q)
            S_IDLE: begin
                if (load_start || unload_start) begin
                    len_d    = xfer_len;
                    count_d  = '0;
                    lane_clr = 1'b1;
                    if (xfer_len == '0) begin
                        state_d = S_FINISH;
                    end else if (load_start) begin
                        state_d = S_LD_WORD;
                    end else begin
                        state_d = S_UL_STROBE;
                    end
                end
            end

            S_LD_WORD: begin
                word_if.in_word_ready = 1'b1;
                if (word_if.in_word_valid) begin
                    lane_word_ld = 1'b1;
                    state_d      = S_LD_STROBE;
                end
            end

            S_LD_STROBE: begin
                sd_buff_wr = 1'b1;
                timer_d    = TMR_W'(1);
                state_d    = S_LD_GAP;
            end

            // The next word is offered in the last gap cycle so word boundaries keep full strobe rate.
            S_LD_GAP: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == T_END) begin
                    count_d = count_inc;
                    if (last_byte) begin
                        state_d = S_FINISH;
                    end else if (lane_full) begin
                        word_if.in_word_ready = 1'b1;
                        if (word_if.in_word_valid) begin
                            lane_word_ld = 1'b1;
                            state_d      = S_LD_STROBE;
                        end else begin
                            state_d = S_LD_WORD;
                        end
                    end else begin
                        lane_inc = 1'b1;
                        state_d  = S_LD_STROBE;
                    end
                end
            end

            S_UL_STROBE: begin
                sd_buff_rd = 1'b1;
                timer_d    = TMR_W'(1);
                state_d    = S_UL_WAIT;
            end

            // A word push takes the final slot of its last access; the count advances on handshake.
            S_UL_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == T_SMP) begin
                    lane_byte_wr = 1'b1;
                end
                if ((lane_full || last_byte) && timer_q == T_PRE) begin
                    state_d = S_UL_PUSH;
                end else if (timer_q == T_END) begin
                    count_d  = count_inc;
                    lane_inc = 1'b1;
                    state_d  = S_UL_STROBE;
                end
            end

            S_UL_PUSH: begin
                word_if.out_word_valid = 1'b1;
                if (word_if.out_word_ready) begin
                    count_d = count_inc;
                    if (last_byte) begin
                        state_d = S_FINISH;
                    end else begin
                        lane_clr = 1'b1;
                        state_d  = S_UL_STROBE;
                    end
                end
            end

            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            timer_q <= timer_d;
        end
    end

    assign sd_buff_addr     = count_q[SS_ADDR_W-1:0];
    assign sd_buff_dout     = lane_byte;
    assign word_if.out_word = shadow_word;

endmodule

// File: tb/tb_save_data_streamer.sv
// Scoreboard bench for save_data_streamer: directed load/unload transfers with
// hand-computed byte writes and unload words checked by a negedge monitor.
module tb_save_data_streamer;

    localparam int ACC = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        load_start = 1'b0;
    logic        unload_start = 1'b0;
    logic [18:0] xfer_len = '0;
    logic [17:0] sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr, sd_buff_rd, busy, done;

    save_data_streamer_if bus ();

    always #5 clk = ~clk;

    // Core read model: the byte at an address equals its low address bits.
    assign sd_buff_din = sd_buff_addr[7:0];

    save_data_streamer #(.ACCESS_CYCLES(16), .RD_SAMPLE(12)) dut (
        .clk_ppu_21_47 (clk),
        .reset_n       (reset_n),
        .load_start    (load_start),
        .unload_start  (unload_start),
        .xfer_len      (xfer_len),
        .word_if       (bus),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_rd    (sd_buff_rd),
        .sd_buff_din   (sd_buff_din),
        .busy          (busy),
        .done          (done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int epoch = 0, mon_epoch = 0;
    int last_wr = 0, last_rd = 0;
    bit have_wr = 0, have_rd = 0;
    bit prev_strobe = 0;
    bit hold_valid = 0;
    logic [31:0] hold_word = '0;
    bit chk_spacing = 0;
    bit rdy_seen = 0;
    bit abort_feed = 0;
    logic [25:0] exp_wr_q[$];
    logic [31:0] exp_word_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n) begin
            if (epoch != mon_epoch) begin
                mon_epoch = epoch;
                have_wr   = 0;
                have_rd   = 0;
            end
            if (bus.in_word_ready) rdy_seen = 1;
            if (sd_buff_wr || sd_buff_rd) begin
                check("strobe_excl_nonconsec", {62'd0, sd_buff_wr & sd_buff_rd, prev_strobe}, 64'd0);
            end
            prev_strobe = sd_buff_wr | sd_buff_rd;
            if (sd_buff_wr) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got addr=%0h data=%0h expected no write", sd_buff_addr, sd_buff_dout);
                end else begin
                    check("wr_addr_data", {sd_buff_addr, sd_buff_dout}, exp_wr_q.pop_front());
                end
                if (chk_spacing && have_wr) check("wr_spacing", cyc - last_wr, ACC);
                have_wr = 1;
                last_wr = cyc;
            end
            if (sd_buff_rd) begin
                rd_cnt++;
                if (chk_spacing && have_rd) check("rd_spacing", cyc - last_rd, ACC);
                have_rd = 1;
                last_rd = cyc;
            end
            if (done) done_cnt++;
            if (bus.out_word_valid) begin
                if (hold_valid) check("out_word_stable", bus.out_word, hold_word);
                if (bus.out_word_ready) begin
                    if (exp_word_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word_unexpected: got=%0h expected no word", bus.out_word);
                    end else begin
                        check("out_word", bus.out_word, exp_word_q.pop_front());
                    end
                    hold_valid = 0;
                end else begin
                    hold_valid = 1;
                    hold_word  = bus.out_word;
                end
            end else begin
                hold_valid = 0;
            end
        end
    end

    task automatic start(input bit ld, input bit ul, input int len);
        @(negedge clk);
        xfer_len     = 19'(len);
        load_start   = ld;
        unload_start = ul;
        epoch++;
        @(negedge clk);
        load_start   = 0;
        unload_start = 0;
    endtask

    task automatic feed(input logic [31:0] w0, input logic [31:0] w1, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_word       = (i == 0) ? w0 : w1;
            bus.in_word_valid = 1'b1;
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (bus.in_word_ready || abort_feed) break;
            end
            if (abort_feed || !bus.in_word_ready) break;
            @(posedge clk);
            #1;
        end
        bus.in_word_valid = 1'b0;
        bus.in_word       = '0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_sdbuf"}, {36'd0, sd_buff_addr, sd_buff_dout, sd_buff_wr, sd_buff_rd}, 64'd0);
        check({name, "_ctl"}, {60'd0, busy, done, bus.in_word_ready, bus.out_word_valid}, 64'd0);
        check({name, "_word"}, {32'd0, bus.out_word}, 64'd0);
    endtask

    initial begin
        int d0, w0, r0;
        bit seen;
        bus.in_word        = '0;
        bus.in_word_valid  = 1'b0;
        bus.out_word_ready = 1'b1;
        #1 reset_n = 1'b0;
        #11 check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Load 6 bytes from two words; 0x77/0x88 must never reach the core.
        for (int i = 0; i < 6; i++) exp_wr_q.push_back({18'(i), 8'(8'h11 * (i + 1))});
        chk_spacing = 1;
        d0 = done_cnt;
        w0 = wr_cnt;
        fork
            feed(32'h44332211, 32'h88776655, 2);
            begin
                start(1, 0, 6);
                check("ld6_busy", {63'd0, busy}, 64'd1);
                wait_done("ld6", 300);
            end
        join
        @(negedge clk);
        check("ld6_busy_after", {63'd0, busy}, 64'd0);
        check("ld6_done_once", done_cnt - d0, 1);
        check("ld6_wr_count", wr_cnt - w0, 6);
        check("ld6_queue_empty", exp_wr_q.size(), 0);

        // Unload 5 bytes: a full word then a partial word with zero upper lanes.
        exp_word_q.push_back(32'h03020100);
        exp_word_q.push_back(32'h00000004);
        d0 = done_cnt;
        r0 = rd_cnt;
        start(0, 1, 5);
        check("ul5_first_rd", {63'd0, sd_buff_rd}, 64'd1);
        wait_done("ul5", 300);
        @(negedge clk);
        check("ul5_rd_count", rd_cnt - r0, 5);
        check("ul5_words_empty", exp_word_q.size(), 0);
        check("ul5_done_once", done_cnt - d0, 1);

        // Consumer stalls 100 cycles on the first unload word.
        chk_spacing = 0;
        bus.out_word_ready = 1'b0;
        exp_word_q.push_back(32'h03020100);
        exp_word_q.push_back(32'h07060504);
        r0 = rd_cnt;
        start(0, 1, 8);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.out_word_valid) begin
                seen = 1;
                break;
            end
        end
        check("stall_valid_seen", {63'd0, seen}, 64'd1);
        w0 = rd_cnt;
        repeat (100) @(negedge clk);
        check("stall_no_rd", rd_cnt - w0, 0);
        check("stall_valid_held", {63'd0, bus.out_word_valid}, 64'd1);
        @(posedge clk);
        #1 bus.out_word_ready = 1'b1;
        wait_done("stall", 300);
        @(negedge clk);
        check("stall_rd_count", rd_cnt - r0, 8);
        check("stall_words_empty", exp_word_q.size(), 0);
        chk_spacing = 1;

        // Zero-length load and unload: immediate done, no strobes, no word ready.
        for (int m = 0; m < 2; m++) begin
            d0 = done_cnt;
            w0 = wr_cnt;
            r0 = rd_cnt;
            rdy_seen = 0;
            start(m == 0, m == 1, 0);
            seen = done;
            if (!seen) begin
                @(negedge clk);
                seen = done;
            end
            check("zero_done_prompt", {63'd0, seen}, 64'd1);
            repeat (3) @(negedge clk);
            check("zero_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
            check("zero_no_ready", {63'd0, rdy_seen}, 64'd0);
            check("zero_done_once", done_cnt - d0, 1);
            check("zero_busy_low", {63'd0, busy}, 64'd0);
        end

        // Asynchronous reset after three load bytes, then a fresh load from address 0.
        for (int i = 0; i < 3; i++) exp_wr_q.push_back({18'(i), 8'(8'h11 * (i + 1))});
        abort_feed = 0;
        w0 = wr_cnt;
        fork
            feed(32'h44332211, 32'h88776655, 2);
            begin
                start(1, 0, 8);
                for (int k = 0; k < 500; k++) begin
                    @(negedge clk);
                    if (wr_cnt - w0 >= 3) break;
                end
                repeat (5) @(negedge clk);
                #2 reset_n = 1'b0;
                #1 check_idle_outputs("midreset");
                abort_feed = 1;
            end
        join
        @(negedge clk);
        reset_n    = 1'b1;
        abort_feed = 0;
        check("midreset_wr_count", wr_cnt - w0, 3);
        check("midreset_queue_empty", exp_wr_q.size(), 0);
        exp_wr_q.push_back({18'd0, 8'hD0});
        exp_wr_q.push_back({18'd1, 8'hC0});
        fork
            feed(32'hA0B0C0D0, 32'h0, 1);
            begin
                start(1, 0, 2);
                wait_done("reload", 200);
            end
        join
        @(negedge clk);
        check("reload_queue_empty", exp_wr_q.size(), 0);

        // Simultaneous starts pick load; starts while busy are ignored.
        for (int i = 0; i < 4; i++) exp_wr_q.push_back({18'(i), 8'(8'h0A + i)});
        d0 = done_cnt;
        r0 = rd_cnt;
        fork
            feed(32'h0D0C0B0A, 32'h0, 1);
            begin
                start(1, 1, 4);
                repeat (20) @(negedge clk);
                check("both_busy", {63'd0, busy}, 64'd1);
                xfer_len     = 19'd9;
                load_start   = 1;
                unload_start = 1;
                @(negedge clk);
                load_start   = 0;
                unload_start = 0;
                wait_done("both", 300);
            end
        join
        repeat (5) @(negedge clk);
        check("both_no_rd", rd_cnt - r0, 0);
        check("both_queue_empty", exp_wr_q.size(), 0);
        check("both_done_once", done_cnt - d0, 1);
        check("both_idle_after", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
